hawk_axiwr_arb: RTL and testbench
=================================

HAWK_AXIWR_ARB -- requirements
Module: hawk_axiwr_arb

Interface
REQ-001 SHALL have parameter NUM_REQ, default 3: number of write requesters (page-write manager, ToL updater, ATT updater); legal range 2..8.
REQ-002 SHALL have port clk_i, input, 1: single clock; all logic on its rising edge.
REQ-003 SHALL have port rst_i, input, 1: reset, asynchronous and active-high.
REQ-004 SHALL have port req_valid_i, input, NUM_REQ: per-requester write request pending.
REQ-005 SHALL have port req_addr_i, input, NUM_REQ x 64: per-requester 64B-block write address.
REQ-006 SHALL have port req_data_i, input, NUM_REQ x 512: per-requester write data.
REQ-007 SHALL have port req_strb_i, input, NUM_REQ x 64: per-requester byte strobes.
REQ-008 SHALL have port req_ready_o, output, NUM_REQ: one-hot, one-cycle payload-accept pulse.
REQ-009 SHALL have port req_done_o, output, NUM_REQ: one-hot, one-cycle completion pulse on B response.
REQ-010 SHALL have port req_err_o, output, 1: valid with req_done_o; equals captured bresp.
REQ-011 SHALL have port wr_req_o, output, axi_wr_reqpkt_t: addr, data, strb, awvalid, wvalid to the AXI write master.
REQ-012 SHALL have port wr_rdy_i, input, axi_wr_rdypkt_t: awready, wready.
REQ-013 SHALL have port wr_resp_i, input, axi_wr_resppkt_t: bresp, bvalid.
REQ-014 SHALL have port bready_o, output, 1: B-channel ready.
REQ-015 SHALL have port busy_o, output, 1: high in any state other than IDLE.
REQ-016 SHALL have port gnt_id_o, output, clogb2(NUM_REQ): index of current grant; held during the transaction.

Function
REQ-017 SHALL implement FSM IDLE -> ISSUE -> WAIT_B -> IDLE; one transaction outstanding at a time.
REQ-018 IDLE: if any req_valid_i is set, SHALL grant round-robin, searching from (last_gnt+1) mod NUM_REQ upward with wrap.
REQ-019 In the grant cycle SHALL pulse req_ready_o[winner], register addr/data/strb and the winner index, and go to ISSUE next cycle.
REQ-020 ISSUE: awvalid and wvalid SHALL assert in the first ISSUE cycle, i.e. 1 cycle after the grant.
REQ-021 awvalid SHALL hold until a cycle with awvalid&&awready, then deassert; wvalid likewise with wready; the two channels complete independently in either order or the same cycle.
REQ-022 Payload (addr, data, strb) SHALL be stable while either valid is high and SHALL not change until return to IDLE.
REQ-023 When both AW and W have completed (tracked by flags aw_done and w_done), SHALL enter WAIT_B the next cycle.
REQ-024 WAIT_B: bready_o SHALL be 1; on bvalid, SHALL pulse req_done_o[gnt] and req_err_o=bresp in the same cycle, set last_gnt=gnt, and return to IDLE.
REQ-025 bvalid outside WAIT_B SHALL be ignored: no done pulse, no state change.
REQ-026 A requester deasserting req_valid_i after its accept SHALL not affect the transaction in flight.
REQ-027 Requests arriving during ISSUE/WAIT_B SHALL wait; arbitration SHALL occur only in IDLE.
REQ-028 Minimum spacing SHALL be 1 IDLE cycle between completion and the next grant.
REQ-029 With all requesters continuously valid, grants SHALL rotate 0,1,...,NUM_REQ-1,0 with no starvation.

Reset
REQ-030 On rst_i (asynchronous, any state including mid-ISSUE/WAIT_B) SHALL force IDLE and clear awvalid, wvalid, bready_o, req_ready_o, req_done_o, req_err_o, busy_o, aw_done, w_done, gnt_id_o=0.
REQ-031 On reset, last_gnt SHALL be NUM_REQ-1 so requester 0 wins first; payload registers SHALL be 0.
REQ-032 An in-flight transaction SHALL be discarded on reset; no done pulse is generated for it.

Verification
REQ-033 Single request, req_valid_i=3'b010, addr 64'hFFF6101000, awready=wready=1 -> req_ready_o[1] at cycle 0, awvalid=wvalid=1 at cycle 1, bready_o high, bvalid at cycle 4 -> req_done_o=3'b010, req_err_o=0.
REQ-034 req_valid_i=3'b111 held, immediate responses -> grant order 0,1,2,0; req_ready_o pulses spaced by one transaction plus 1 IDLE cycle.
REQ-035 awready at cycle 1 while wready is delayed to cycle 5 -> awvalid drops after cycle 1; wvalid is held with stable data through cycle 5; WAIT_B is entered at cycle 6.
REQ-036 bresp=1 with bvalid -> req_done_o[gnt] and req_err_o=1 in the same cycle; FSM returns to IDLE.
REQ-037 rst_i asserted in WAIT_B -> outputs clear immediately; no req_done_o; the next grant after reset goes to requester 0.
REQ-038 Spurious bvalid in IDLE -> no req_done_o, busy_o stays 0.

Source files
------------

// File: rtl/hawk_axiwr_arb.sv
// hawk_axiwr_arb: round-robin arbiter feeding one AXI write transaction at a time to a write master.
//   clk_i, rst_i (async, active-high)
//   req_valid_i/addr/data/strb : per-requester write requests
//   req_ready_o : one-hot payload-accept pulse, req_done_o/req_err_o : completion pulse + bresp
//   wr_req_o/wr_rdy_i/wr_resp_i/bready_o : AXI AW/W/B side
//   busy_o : not IDLE, gnt_id_o : index of the current grant
package hawk_axiwr_pkg;
    typedef struct packed {
        logic [63:0]  addr;
        logic [511:0] data;
        logic [63:0]  strb;
        logic         awvalid;
        logic         wvalid;
    } axi_wr_reqpkt_t;
    typedef struct packed {
        logic awready;
        logic wready;
    } axi_wr_rdypkt_t;
    typedef struct packed {
        logic bresp;
        logic bvalid;
    } axi_wr_resppkt_t;
endpackage

module hawk_axiwr_arb
    import hawk_axiwr_pkg::*;
#(
    parameter int NUM_REQ = 3
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [NUM_REQ-1:0]                req_valid_i,
    input  logic [NUM_REQ-1:0][63:0]          req_addr_i,
    input  logic [NUM_REQ-1:0][511:0]         req_data_i,
    input  logic [NUM_REQ-1:0][63:0]          req_strb_i,
    output logic [NUM_REQ-1:0]                req_ready_o,
    output logic [NUM_REQ-1:0]                req_done_o,
    output logic                              req_err_o,
    output axi_wr_reqpkt_t                    wr_req_o,
    input  axi_wr_rdypkt_t                    wr_rdy_i,
    input  axi_wr_resppkt_t                   wr_resp_i,
    output logic                              bready_o,
    output logic                              busy_o,
    output logic [$clog2(NUM_REQ)-1:0]        gnt_id_o
);
    localparam int GW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_B} state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   last_gnt_q, gnt_q, win;
    logic            aw_done_q, w_done_q, aw_hs, w_hs, grant, done;
    logic [63:0]     addr_q, strb_q;
    logic [511:0]    data_q;

    // Lowest valid index above last_gnt wins; otherwise wrap to the lowest valid index.
    always_comb begin
        win = last_gnt_q;
        for (int i = NUM_REQ - 1; i >= 0; i--)
            if (req_valid_i[i]) win = GW'(i);
        for (int i = NUM_REQ - 1; i >= 0; i--)
            if (req_valid_i[i] && i > int'(last_gnt_q)) win = GW'(i);
    end

    always_comb begin
        state_d = state_q;
        grant   = state_q == IDLE && |req_valid_i;
        aw_hs   = wr_req_o.awvalid && wr_rdy_i.awready;
        w_hs    = wr_req_o.wvalid && wr_rdy_i.wready;
        done    = state_q == WAIT_B && wr_resp_i.bvalid;
        case (state_q)
            IDLE:    if (grant) state_d = ISSUE;
            ISSUE:   if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = WAIT_B;
            WAIT_B:  if (done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_req_o.addr    = addr_q;
        wr_req_o.data    = data_q;
        wr_req_o.strb    = strb_q;
        wr_req_o.awvalid = state_q == ISSUE && !aw_done_q;
        wr_req_o.wvalid  = state_q == ISSUE && !w_done_q;
        // Accept is combinational in IDLE, so mask it while reset is held.
        req_ready_o      = (grant && !rst_i) ? NUM_REQ'(1) << win : '0;
        req_done_o       = done ? NUM_REQ'(1) << gnt_q : '0;
        req_err_o        = done && wr_resp_i.bresp;
        bready_o         = state_q == WAIT_B;
        busy_o           = state_q != IDLE;
        gnt_id_o         = gnt_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            last_gnt_q <= GW'(NUM_REQ - 1);
            gnt_q      <= '0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            strb_q     <= '0;
        end else begin
            state_q   <= state_d;
            // Channel flags live only while in ISSUE, so they are clean for the next transaction.
            aw_done_q <= state_d == ISSUE && (aw_done_q || aw_hs);
            w_done_q  <= state_d == ISSUE && (w_done_q || w_hs);
            if (grant) begin
                gnt_q  <= win;
                addr_q <= req_addr_i[win];
                data_q <= req_data_i[win];
                strb_q <= req_strb_i[win];
            end
            if (done) last_gnt_q <= gnt_q;
        end
    end
endmodule

// File: tb/tb_hawk_axiwr_arb.sv
// tb_hawk_axiwr_arb: table-driven, scoreboard-checked bench for hawk_axiwr_arb.
module tb_hawk_axiwr_arb;
    import hawk_axiwr_pkg::*;
    localparam int N = 3;

    logic                 clk_i = 1'b0;
    logic                 rst_i;
    logic [N-1:0]         req_valid_i;
    logic [N-1:0][63:0]   req_addr_i;
    logic [N-1:0][511:0]  req_data_i;
    logic [N-1:0][63:0]   req_strb_i;
    logic [N-1:0]         req_ready_o, req_done_o;
    logic                 req_err_o, bready_o, busy_o;
    logic [1:0]           gnt_id_o;
    axi_wr_reqpkt_t       wr_req_o;
    axi_wr_rdypkt_t       wr_rdy_i;
    axi_wr_resppkt_t      wr_resp_i;

    hawk_axiwr_arb #(.NUM_REQ(N)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_valid_i(req_valid_i), .req_addr_i(req_addr_i),
        .req_data_i(req_data_i), .req_strb_i(req_strb_i), .req_ready_o(req_ready_o),
        .req_done_o(req_done_o), .req_err_o(req_err_o), .wr_req_o(wr_req_o),
        .wr_rdy_i(wr_rdy_i), .wr_resp_i(wr_resp_i), .bready_o(bready_o),
        .busy_o(busy_o), .gnt_id_o(gnt_id_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [N-1:0] mask;
        int           awd, wd, bd;
        logic         bresp;
        int           gnt;
    } vec_t;

    typedef struct {
        int           gnt;
        logic [63:0]  addr;
        logic [511:0] data;
        logic [63:0]  strb;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[11];
    int   n_vec = 0, n_err = 0;

    task automatic check(input string nm, input logic [639:0] act, input logic [639:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fill_payload(input int salt);
        for (int i = 0; i < N; i++) begin
            req_addr_i[i] = 64'hFFF6100000 + 64'(i) * 64'h1000 + (64'(salt) << 24);
            req_data_i[i] = {16{32'(salt * 7 + i) ^ 32'hA5A5_0000}};
            req_strb_i[i] = {8{8'(salt * 3 + i + 1)}};
        end
    endtask

    task automatic txn(input vec_t v, input int salt);
        int   t_aw, t_w, t_b, t_d;
        exp_t e;
        t_aw = 1 + v.awd;
        t_w  = 1 + v.wd;
        t_b  = (t_aw > t_w ? t_aw : t_w) + 1;
        t_d  = t_b + v.bd;
        @(negedge clk_i);
        fill_payload(salt);
        req_valid_i = v.mask;
        wr_rdy_i = '0;
        wr_resp_i = '0;
        #1;
        check("grant", {busy_o, req_ready_o}, {1'b0, N'(1) << v.gnt});
        e.gnt  = v.gnt;
        e.addr = req_addr_i[v.gnt];
        e.data = req_data_i[v.gnt];
        e.strb = req_strb_i[v.gnt];
        sb.push_back(e);
        for (int c = 1; c <= t_d; c++) begin
            @(negedge clk_i);
            req_valid_i = '0;
            fill_payload(salt + 100);
            wr_rdy_i.awready = c >= t_aw;
            wr_rdy_i.wready  = c >= t_w;
            wr_resp_i.bvalid = c == 1 || c == t_d;
            wr_resp_i.bresp  = v.bresp;
            #1;
            check("ctl", {wr_req_o.awvalid, wr_req_o.wvalid, bready_o, busy_o, gnt_id_o, req_done_o, req_err_o},
                  {c <= t_aw, c <= t_w, c >= t_b, 1'b1, 2'(v.gnt),
                   (c == t_d) ? N'(1) << sb[0].gnt : N'(0), c == t_d && v.bresp});
            if (c < t_b)
                check("payload", {wr_req_o.addr, wr_req_o.data, wr_req_o.strb}, {sb[0].addr, sb[0].data, sb[0].strb});
        end
        void'(sb.pop_front());
    endtask

    initial begin
        tbl[0]  = '{3'b111, 0, 0, 0, 1'b0, 0};
        tbl[1]  = '{3'b111, 0, 0, 0, 1'b0, 1};
        tbl[2]  = '{3'b111, 0, 0, 0, 1'b0, 2};
        tbl[3]  = '{3'b111, 0, 0, 0, 1'b0, 0};
        tbl[4]  = '{3'b010, 0, 0, 2, 1'b0, 1};
        tbl[5]  = '{3'b111, 0, 4, 1, 1'b0, 2};
        tbl[6]  = '{3'b101, 3, 0, 0, 1'b1, 0};
        tbl[7]  = '{3'b100, 2, 2, 3, 1'b0, 2};
        tbl[8]  = '{3'b011, 0, 1, 0, 1'b0, 0};
        tbl[9]  = '{3'b110, 1, 0, 0, 1'b0, 1};
        tbl[10] = '{3'b001, 0, 0, 1, 1'b1, 0};

        rst_i = 1'b1;
        req_valid_i = '0;
        fill_payload(0);
        wr_rdy_i = '0;
        wr_resp_i = '0;
        repeat (2) @(negedge clk_i);
        #1;
        check("reset_ctl", {busy_o, bready_o, wr_req_o.awvalid, wr_req_o.wvalid, req_ready_o, req_done_o, req_err_o, gnt_id_o}, '0);
        check("reset_payload", {wr_req_o.addr, wr_req_o.data, wr_req_o.strb}, '0);
        @(negedge clk_i);
        rst_i = 1'b0;

        for (int i = 0; i < 11; i++) txn(tbl[i], i == 4 ? 0 : i + 1);

        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            req_valid_i = '0;
            wr_resp_i.bvalid = 1'b1;
            wr_resp_i.bresp = 1'b1;
            #1;
            check("spurious_b", {req_done_o, req_err_o, busy_o, bready_o}, '0);
        end

        @(negedge clk_i);
        wr_resp_i = '0;
        fill_payload(50);
        req_valid_i = 3'b100;
        #1;
        check("rst_grant", req_ready_o, 3'b100);
        @(negedge clk_i);
        req_valid_i = '0;
        wr_rdy_i.awready = 1'b1;
        wr_rdy_i.wready = 1'b1;
        @(negedge clk_i);
        #1;
        check("rst_waitb", {busy_o, bready_o, gnt_id_o}, {1'b1, 1'b1, 2'd2});
        @(negedge clk_i);
        req_valid_i = 3'b111;
        wr_resp_i.bvalid = 1'b1;
        rst_i = 1'b1;
        #1;
        check("rst_midflight", {busy_o, bready_o, wr_req_o.awvalid, wr_req_o.wvalid, req_ready_o, req_done_o, req_err_o, gnt_id_o}, '0);
        check("rst_addr", wr_req_o.addr, '0);
        sb.delete();
        @(negedge clk_i);
        rst_i = 1'b0;
        wr_resp_i = '0;
        wr_rdy_i = '0;
        #1;
        check("rst_next_grant", req_ready_o, 3'b001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
